// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b memory-path types: the 16-bit word, the 128-bit
//               cache line and the 3-bit beat index that selects a word
//               within a line.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;
    typedef logic [2:0]   lc3b_beat;

    // 16-bit words per 128-bit line
    localparam int LINE_WORDS = 8;

endpackage
`default_nettype wire

// File: rtl/line_beat_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_beat_buffer
// Description : One cache line held as LINE_WORDS 16-bit words. The whole line
//               can be loaded at once, or a single word can be loaded at a
//               beat index. The full line and one word chosen by a separate
//               read index are always visible.
// Ports       : clk       - clock
//               reset_n   - asynchronous active-low clear
//               line_load - load all words from line_in (wins over word_load)
//               line_in   - line to load
//               word_load - load word_in into word[word_idx]
//               word_idx  - beat index for word_load
//               word_in   - word to load
//               rd_idx    - beat index for word_out
//               line_out  - full stored line, word k at bits [16k+15:16k]
//               word_out  - stored word[rd_idx]
// Revision    : 1.0 - initial release
// ============================================================================
module line_beat_buffer
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      line_load,
    input  cache_line line_in,
    input  logic      word_load,
    input  lc3b_beat  word_idx,
    input  lc3b_word  word_in,
    input  lc3b_beat  rd_idx,
    output cache_line line_out,
    output lc3b_word  word_out
);

    lc3b_word r_words [LINE_WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (line_load) begin
                    r_words[i] <= line_in[16*i +: 16];
                end else if (word_load && (word_idx == lc3b_beat'(i))) begin
                    r_words[i] <= word_in;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            assign line_out[16*gi +: 16] = r_words[gi];
        end
    endgenerate

    assign word_out = r_words[rd_idx];

endmodule
`default_nettype wire

// File: rtl/cacheline_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_pmem_responder
// Description : Memory-side responder for an L1 cache. Each 128-bit line read
//               or write request is carried out as LINE_WORDS sequential
//               16-bit word transfers on the physical-memory bus, lowest
//               address first, followed by a one-cycle mem_resp.
// Ports       : clk, reset_n      - clock, asynchronous active-low reset
//               mem_address       - line byte address (bits [3:0] ignored)
//               mem_read/write    - level line requests (write has priority)
//               mem_wdata         - line to write
//               mem_resp          - one-cycle completion pulse
//               mem_rdata         - assembled read line
//               pmem_address      - word byte address {line, beat, 1'b0}
//               pmem_read/write   - word strobes, held until pmem_resp
//               pmem_wdata        - word being written
//               pmem_rdata        - returned word, valid with pmem_resp
//               pmem_resp         - word transfer done
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_pmem_responder
    import lc3b_types::cache_line, lc3b_types::lc3b_word, lc3b_types::lc3b_beat;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  cache_line             mem_wdata,
    output logic                  mem_resp,
    output cache_line             mem_rdata,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output lc3b_word              pmem_wdata,
    input  lc3b_word              pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam lc3b_beat c_last_beat = lc3b_beat'(LINE_WORDS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [ADDR_WIDTH-5:0] r_line_addr;
    lc3b_beat              r_beat;
    lc3b_word              r_pmem_wdata;

    logic      w_accept_wr;
    logic      w_accept_rd;
    logic      w_strobe;
    logic      w_beat_done;
    logic      w_last;
    lc3b_beat  w_next_beat;
    lc3b_word  w_wr_next_word;
    lc3b_word  w_rd_word_unused;
    cache_line w_wr_line_unused;
    logic [3:0] w_addr_low_unused;

    // Byte offset within the line plays no part in the transfer
    assign w_addr_low_unused = mem_address[3:0];

    // Write takes priority; a concurrent read stays pending for the next IDLE
    assign w_accept_wr = (r_state == c_st_idle) && mem_write;
    assign w_accept_rd = (r_state == c_st_idle) && !mem_write && mem_read;
    assign w_strobe    = (r_state == c_st_read) || (r_state == c_st_write);
    assign w_beat_done = w_strobe && pmem_resp;
    assign w_last      = (r_beat == c_last_beat);
    assign w_next_beat = r_beat + 3'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept_wr) begin
                    w_next_state = c_st_write;
                end else if (w_accept_rd) begin
                    w_next_state = c_st_read;
                end
            end
            c_st_read, c_st_write: begin
                if (w_beat_done && w_last) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state; reset drops them without a clock edge
    // ------------------------------------------------------------------
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        mem_resp   = 1'b0;
        case (r_state)
            c_st_read:  pmem_read  = 1'b1;
            c_st_write: pmem_write = 1'b1;
            c_st_resp:  mem_resp   = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Line address, beat counter and outgoing write word.
    // pmem_wdata is a register preloaded one beat ahead so it holds its
    // value outside write transfers instead of following the beat counter
    // through unrelated reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_addr  <= '0;
            r_beat       <= '0;
            r_pmem_wdata <= '0;
        end else begin
            if (w_accept_wr || w_accept_rd) begin
                r_line_addr <= mem_address[ADDR_WIDTH-1:4];
                r_beat      <= '0;
            end else if (w_beat_done && !w_last) begin
                r_beat <= w_next_beat;
            end

            if (w_accept_wr) begin
                r_pmem_wdata <= mem_wdata[15:0];
            end else if (w_beat_done && (r_state == c_st_write) && !w_last) begin
                r_pmem_wdata <= w_wr_next_word;
            end
        end
    end

    // Write-data latch: whole line captured at acceptance, read back one
    // word ahead of the current beat
    line_beat_buffer u_wr_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_load (w_accept_wr),
        .line_in   (mem_wdata),
        .word_load (1'b0),
        .word_idx  (3'd0),
        .word_in   (16'd0),
        .rd_idx    (w_next_beat),
        .line_out  (w_wr_line_unused),
        .word_out  (w_wr_next_word)
    );

    // Read assembly: one word captured per completed read beat
    line_beat_buffer u_rd_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_load (1'b0),
        .line_in   ('0),
        .word_load (w_beat_done && (r_state == c_st_read)),
        .word_idx  (r_beat),
        .word_in   (pmem_rdata),
        .rd_idx    (r_beat),
        .line_out  (mem_rdata),
        .word_out  (w_rd_word_unused)
    );

    assign pmem_address = {r_line_addr, r_beat, 1'b0};
    assign pmem_wdata   = r_pmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_pmem_responder
// Description : Scoreboard bench for cacheline_pmem_responder. Stimulus pushes
//               expected word beats and line responses into queues; a monitor
//               pops and compares whenever the DUT completes a beat or pulses
//               mem_resp. A small pmem model supplies configurable wait states
//               and returns each word's own byte address as read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_pmem_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_wdata;
    logic [15:0]  pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cacheline_pmem_responder #(
        .LINE_WORDS (8),
        .ADDR_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
    } resp_t;

    beat_t        beat_q[$];
    resp_t        resp_q[$];
    logic [127:0] exp_line;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           pm_waits = 0;
    bit           spurious = 1'b0;
    int           wcnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // pmem model: settles its response shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (pmem_read || pmem_write) begin
            pmem_rdata = pmem_address;
            if (wcnt >= pm_waits) begin
                pmem_resp = 1'b1;
                wcnt = 0;
            end else begin
                pmem_resp = 1'b0;
                wcnt++;
            end
        end else begin
            pmem_resp  = spurious;
            pmem_rdata = 16'hBEEF;
            wcnt = 0;
        end
    end

    // Monitor: compares completed beats and line responses against the queues
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (reset_n) begin
            if (pmem_read && pmem_write) begin
                total++;
                bad++;
                $display("FAIL strobe_excl: got both strobes high want one (cycle %0d)", cyc);
            end
            if ((pmem_read || pmem_write) && pmem_resp) begin
                if (beat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got beat at %0h want none (cycle %0d)", pmem_address, cyc);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_kind_wr", pmem_write, b.wr);
                    chk("beat_addr", pmem_address, b.addr);
                    if (b.wr) chk("beat_wdata", pmem_wdata, b.wdata);
                end
            end
            if (mem_resp) begin
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got mem_resp want none (cycle %0d)", cyc);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_cycle", cyc, r.cyc);
                    chk("resp_rdata", mem_rdata, r.rdata);
                end
            end
        end
    end

    // Queue the expected beats (first nbeats of the line) and optionally the
    // line response. c0 is the cycle in which the request is sampled in IDLE.
    task automatic push_line(input bit wr, input logic [15:0] addr, input logic [127:0] wdata,
                             input int waits, input int c0, input int nbeats, input bit want_resp);
        logic [15:0] base;
        beat_t       b;
        resp_t       r;
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < nbeats; k++) begin
            b.wr    = wr;
            b.addr  = base + 16'(2 * k);
            b.wdata = wdata[16*k +: 16];
            beat_q.push_back(b);
        end
        if (!wr) begin
            for (int k = 0; k < 8; k++) exp_line[16*k +: 16] = base + 16'(2 * k);
        end
        if (want_resp) begin
            r.cyc   = c0 + 9 + 8 * waits;
            r.rdata = exp_line;
            resp_q.push_back(r);
        end
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_resp && n < 200);
        if (!mem_resp) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no mem_resp want one within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        logic [127:0] wl;
        int           c0;

        reset_n     = 1'b0;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        exp_line    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        reset_n = 1'b1;

        // Spurious pmem_resp in IDLE with no request
        spurious = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_strobes", {pmem_read, pmem_write, mem_resp}, 0);
            chk("idle_rdata", mem_rdata, 0);
        end
        spurious = 1'b0;
        @(negedge clk);

        // Zero-wait line read at 0x1234
        pm_waits    = 0;
        mem_address = 16'h1234;
        mem_read    = 1'b1;
        push_line(1'b0, 16'h1234, '0, 0, cyc, 8, 1'b1);
        wait_resp();
        mem_read = 1'b0;
        @(negedge clk);
        chk("t1_rdata_hold", mem_rdata, 128'h123E_123C_123A_1238_1236_1234_1232_1230);

        // Line write at 0x8000, two wait cycles per beat
        for (int k = 0; k < 8; k++) wl[16*k +: 16] = 16'hA000 + 16'(k);
        pm_waits    = 2;
        mem_address = 16'h8000;
        mem_wdata   = wl;
        mem_write   = 1'b1;
        push_line(1'b1, 16'h8000, wl, 2, cyc, 8, 1'b1);
        wait_resp();
        mem_write = 1'b0;
        @(negedge clk);
        chk("t2_rdata_unchanged", mem_rdata, 128'h123E_123C_123A_1238_1236_1234_1232_1230);

        // Simultaneous read and write at 0x0040: write first, then read
        for (int k = 0; k < 8; k++) wl[16*k +: 16] = 16'h5500 + 16'(k);
        pm_waits    = 0;
        mem_address = 16'h0040;
        mem_wdata   = wl;
        mem_write   = 1'b1;
        mem_read    = 1'b1;
        c0 = cyc;
        push_line(1'b1, 16'h0040, wl, 0, c0, 8, 1'b1);
        push_line(1'b0, 16'h0040, '0, 0, c0 + 10, 8, 1'b1);
        wait_resp();
        mem_write = 1'b0;
        wait_resp();
        mem_read = 1'b0;
        @(negedge clk);

        // Address change after beat 2 must not affect the transfer
        mem_address = 16'h2000;
        mem_read    = 1'b1;
        push_line(1'b0, 16'h2000, '0, 0, cyc, 8, 1'b1);
        repeat (3) @(negedge clk);
        mem_address = 16'hFFF0;
        wait_resp();
        mem_read = 1'b0;
        @(negedge clk);

        // Reset during beat 4 of a read: beats 0..4 seen, no response
        mem_address = 16'h3000;
        mem_read    = 1'b1;
        push_line(1'b0, 16'h3000, '0, 0, cyc, 5, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_pmem_read", pmem_read, 0);
        chk("midrst_mem_resp", mem_resp, 0);
        chk("midrst_mem_rdata", mem_rdata, 0);
        chk("midrst_pmem_address", pmem_address, 0);
        mem_read = 1'b0;
        exp_line = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Fresh read at 0x0100 after reset
        mem_address = 16'h0100;
        mem_read    = 1'b1;
        push_line(1'b0, 16'h0100, '0, 0, cyc, 8, 1'b1);
        wait_resp();
        mem_read = 1'b0;
        repeat (3) @(negedge clk);

        chk("beat_q_drained", beat_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
